// File: rtl/dac_feed_pkg.sv
// ---------------------------------------------------------------------------
// dac_feed_pkg
// Shared definitions for the DAC sample feeder: sample width and the
// dispatch FSM state encoding used by dac_sample_feeder.
// ---------------------------------------------------------------------------
package dac_feed_pkg;

   // Width of one DAC sample (MCP47FEB is a 12-bit part)
   localparam int SAMPLE_W = 12;

   // Dispatch FSM states; the encoding is fixed so a debugger can read it raw
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } feed_state_t;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous first-word-fall-through FIFO with a level output and a
// single-cycle flush. The head entry is visible on rd_data whenever
// empty is low, so the consumer can take it in the same cycle it pops.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   flush    in   drop all entries; overrides push and pop in that cycle
//   push     in   write wr_data (ignored while full)
//   wr_data  in   WIDTH-bit entry to store
//   pop      in   discard the head entry (ignored while empty)
//   rd_data  out  head entry (valid while !empty)
//   full     out  no free slot
//   empty    out  no entry held
//   level    out  number of entries held, 0..2^AW
// ---------------------------------------------------------------------------
import dac_feed_pkg::*;

module sample_fifo #(
   parameter int WIDTH = SAMPLE_W,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit, so their difference is the fill level
   // and full/empty need no separate flag registers
   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush collapses both pointers back to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array has no reset; stale contents are never read because
   // the consumer only looks at rd_data while the FIFO is non-empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// dac_sample_feeder
// Front end of the MCP47FEB I2C DAC writer. Buffers producer samples,
// paces them at one slot every rate_div+1 clocks and hands each sample to
// the writer through ch_value/enable, respecting the writer's busy flag.
// Empty-FIFO slots count as underruns; slots that arrive while the previous
// one has not been dispatched count as slips.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   s_data        in   sample from producer
//   s_valid       in   s_data valid
//   s_ready       out  FIFO can accept (not full)
//   run           in   1 = issue samples at slot rate
//   flush         in   pulse: empty the FIFO
//   rate_div      in   slot period minus one, in clk cycles
//   clear_status  in   pulse: zero counters and the sticky underrun flag
//   dac_busy      in   busy from the DAC writer
//   ch_value      out  sample presented to the writer
//   enable        out  transfer request to the writer
//   fifo_level    out  entries held in the FIFO
//   underrun      out  sticky, set by an empty-FIFO slot
//   underrun_cnt  out  saturating count of empty-FIFO slots
//   slip_cnt      out  saturating count of slots lost to a busy writer
// ---------------------------------------------------------------------------
import dac_feed_pkg::*;

module dac_sample_feeder #(
   parameter int FIFO_AW = 4,
   parameter int RATE_W  = 16,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                run,
   input  logic                flush,
   input  logic [RATE_W-1:0]   rate_div,
   input  logic                clear_status,
   input  logic                dac_busy,
   output logic [SAMPLE_W-1:0] ch_value,
   output logic                enable,
   output logic [FIFO_AW:0]    fifo_level,
   output logic                underrun,
   output logic [CNT_W-1:0]    underrun_cnt,
   output logic [CNT_W-1:0]    slip_cnt
);

   feed_state_t         state;
   logic [RATE_W-1:0]   timer;
   logic                pending;
   logic                tick;
   logic                consume;
   logic                slip;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [SAMPLE_W-1:0] fifo_head;

   // A slot fires when the down-counter sits at zero while running.
   // A pending slot is consumed (sent or reported as underrun) only from
   // IDLE with the writer free. Flush defers the consume by a cycle so
   // ch_value is never loaded from an entry that is being discarded.
   // A tick that lands on an unconsumed pending slot is a slip; a tick in
   // the same cycle as a consume simply re-arms pending.
   assign s_ready  = !fifo_full;
   assign tick     = run && (timer == '0);
   assign consume  = run && pending && !dac_busy && !flush && (state == IDLE);
   assign slip     = tick && pending && !consume;
   assign fifo_pop = consume && !fifo_empty;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (s_valid),
      .wr_data (s_data),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Slot timer: parked at rate_div while stopped so the first slot after
   // run rises comes a full period later; new rate_div values only take
   // effect on reload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (!run) begin
         timer <= rate_div;
      end else if (timer == '0) begin
         timer <= rate_div;
      end else begin
         timer <= timer - 1'b1;
      end
   end

   // Pending slot flag plus the saturating slip counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         slip_cnt <= '0;
      end else begin
         if (!run) begin
            pending <= 1'b0;
         end else if (tick) begin
            pending <= 1'b1;
         end else if (consume) begin
            pending <= 1'b0;
         end

         if (clear_status) begin
            slip_cnt <= '0;
         end else if (slip && (slip_cnt != '1)) begin
            slip_cnt <= slip_cnt + 1'b1;
         end
      end
   end

   // Dispatch FSM: IDLE loads ch_value and raises enable, ISSUE holds the
   // request until the writer reports busy, WAIT_DONE waits for it to finish.
   // ch_value is left untouched on underrun so the DAC keeps its last level.
   // clear_status is applied last so it beats a same-cycle underrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ch_value     <= '0;
         enable       <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (consume) begin
                  if (fifo_empty) begin
                     underrun <= 1'b1;
                     if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
                  end else begin
                     ch_value <= fifo_head;
                     enable   <= 1'b1;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (dac_busy) begin
                  enable <= 1'b0;
                  state  <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!dac_busy) state <= IDLE;
            end
            default: begin
               enable <= 1'b0;
               state  <= IDLE;
            end
         endcase

         if (clear_status) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_feeder
// Self-checking bench for dac_sample_feeder. Accepted producer samples are
// queued as expectations; a DAC-writer model pops and compares them each
// time it latches a request.
// ---------------------------------------------------------------------------
import dac_feed_pkg::*;

module tb_dac_sample_feeder;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [SAMPLE_W-1:0] s_data = '0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic                run = 1'b0;
   logic                flush = 1'b0;
   logic [15:0]         rate_div = 16'd0;
   logic                clear_status = 1'b0;
   logic                dac_busy = 1'b0;
   logic [SAMPLE_W-1:0] ch_value;
   logic                enable;
   logic [4:0]          fifo_level;
   logic                underrun;
   logic [15:0]         underrun_cnt;
   logic [15:0]         slip_cnt;

   int n_check = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int n_latch = 0;
   int busy_len = 40;
   int wr_cnt  = 0;
   bit wr_latched = 1'b0;
   bit slip_mode  = 1'b0;
   int slip_base  = 0;

   logic [SAMPLE_W-1:0] exp_q[$];
   int                  lat_cyc[$];

   typedef struct {
      logic                valid;
      logic [SAMPLE_W-1:0] data;
      logic                exp_acc;
      logic [4:0]          exp_level;
      logic                exp_ready;
   } vec_t;

   vec_t vecs[18];

   dac_sample_feeder #(
      .FIFO_AW (4),
      .RATE_W  (16),
      .CNT_W   (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .run          (run),
      .flush        (flush),
      .rate_div     (rate_div),
      .clear_status (clear_status),
      .dac_busy     (dac_busy),
      .ch_value     (ch_value),
      .enable       (enable),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .slip_cnt     (slip_cnt)
   );

   // 100 MHz-style clock and a free-running cycle counter for spacing checks
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int actual, input int expected);
      n_check++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   // DAC writer model, run on the falling edge: it latches a request, raises
   // busy one cycle later and holds it for busy_len cycles. Every latch is
   // compared against the head of the scoreboard.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_busy   = 1'b0;
         wr_cnt     = 0;
         wr_latched = 1'b0;
      end else if (wr_latched) begin
         dac_busy   = 1'b1;
         wr_cnt     = busy_len - 1;
         wr_latched = 1'b0;
      end else if (dac_busy) begin
         if (wr_cnt == 0) dac_busy = 1'b0;
         else wr_cnt--;
      end else if (enable) begin
         wr_latched = 1'b1;
         n_latch++;
         lat_cyc.push_back(cyc);
         check("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("dispatch_value", ch_value, exp_q.pop_front());
         if (slip_mode && (n_latch - slip_base == 2))  check("slip_cnt_at_2nd", slip_cnt, 42);
         if (slip_mode && (n_latch - slip_base == 16)) check("slip_cnt_at_16th", slip_cnt, 15 * 42);
      end
   end

   // Drive one table record (called at a falling edge) and note acceptance
   task automatic apply_stimulus(input vec_t v, output logic acc);
      s_valid = v.valid;
      s_data  = v.data;
      acc     = s_valid && s_ready;
      if (acc) exp_q.push_back(v.data);
   endtask

   task automatic check_output(input vec_t v, input int idx);
      check($sformatf("fill_level[%0d]", idx), fifo_level, v.exp_level);
      check($sformatf("fill_ready[%0d]", idx), s_ready, v.exp_ready);
   endtask

   task automatic push_sample(input logic [SAMPLE_W-1:0] d);
      s_valid = 1'b1;
      s_data  = d;
      if (s_ready) exp_q.push_back(d);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
   endtask

   task automatic wait_latches(input int target, input int budget, input string name);
      int k = 0;
      while (n_latch < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, n_latch, target);
   endtask

   // Watchdog: a hang is reported and ends the run
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_check);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic acc;
      int   base;

      for (int i = 0; i < 18; i++) begin
         vecs[i].valid     = (i < 17);
         vecs[i].data      = SAMPLE_W'(12'hA00 + i);
         vecs[i].exp_acc   = (i < 16);
         vecs[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
         vecs[i].exp_ready = (i < 15);
      end

      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ch_value", ch_value, 0);
      check("rst_enable", enable, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_level", fifo_level, 0);
      check("rst_underrun", underrun, 0);
      check("rst_underrun_cnt", underrun_cnt, 0);
      check("rst_slip_cnt", slip_cnt, 0);

      // Fill 17 with run=0: 16 taken, 17th held off by s_ready
      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i], acc);
         check($sformatf("fill_accept[%0d]", i), acc, vecs[i].exp_acc);
         @(negedge clk);
         check_output(vecs[i], i);
      end
      s_valid = 1'b0;

      // Flush a full FIFO, then flush at level 8 while a push is offered
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_q.delete();
      check("flush_full_level", fifo_level, 0);
      for (int i = 0; i < 8; i++) push_sample(SAMPLE_W'(12'h300 + i));
      check("level_before_flush", fifo_level, 8);
      s_valid = 1'b1;
      s_data  = 12'h3FF;
      flush   = 1'b1;
      @(negedge clk);
      flush   = 1'b0;
      s_valid = 1'b0;
      exp_q.delete();
      check("flush_with_push_level", fifo_level, 0);
      check("flush_with_push_ready", s_ready, 1);

      // Three samples at rate_div=99: one dispatch every 100 cycles, in order
      busy_len = 40;
      push_sample(12'h123);
      push_sample(12'h456);
      push_sample(12'hFFF);
      rate_div = 16'd99;
      @(negedge clk);
      lat_cyc.delete();
      base = n_latch;
      run = 1'b1;
      wait_latches(base + 3, 500, "paced_latches");
      run = 1'b0;
      if (lat_cyc.size() >= 3) begin
         check("paced_spacing_1", lat_cyc[1] - lat_cyc[0], 100);
         check("paced_spacing_2", lat_cyc[2] - lat_cyc[1], 100);
      end else begin
         check("paced_latch_count", lat_cyc.size(), 3);
      end
      repeat (60) @(negedge clk);
      check("paced_no_underrun", underrun, 0);
      check("paced_slip_cnt", slip_cnt, 0);
      check("paced_enable_idle", enable, 0);
      check("paced_last_value_held", ch_value, 12'hFFF);

      // Empty FIFO, rate_div=9: five empty slots, no requests
      rate_div = 16'd9;
      repeat (2) @(negedge clk);
      base = n_latch;
      run = 1'b1;
      repeat (51) @(negedge clk);
      run = 1'b0;
      check("underrun_flag", underrun, 1);
      check("underrun_cnt", underrun_cnt, 5);
      check("underrun_no_enable", n_latch, base);
      check("underrun_ch_value_held", ch_value, 12'hFFF);
      pulse_clear();
      check("clear_underrun", underrun, 0);
      check("clear_underrun_cnt", underrun_cnt, 0);
      check("clear_slip_cnt", slip_cnt, 0);

      // rate_div=0 with a full FIFO and a slow writer: slips, each sample once
      for (int i = 0; i < 16; i++) push_sample(SAMPLE_W'(12'h500 + 7 * i));
      check("slip_level_full", fifo_level, 16);
      rate_div = 16'd0;
      @(negedge clk);
      base      = n_latch;
      slip_base = n_latch;
      slip_mode = 1'b1;
      run = 1'b1;
      wait_latches(base + 16, 1500, "slip_latches");
      run = 1'b0;
      slip_mode = 1'b0;
      repeat (60) @(negedge clk);
      check("slip_no_extra_dispatch", n_latch, base + 16);
      check("slip_fifo_drained", fifo_level, 0);
      check("slip_scoreboard_empty", exp_q.size(), 0);
      pulse_clear();
      check("slip_cleared", slip_cnt, 0);

      // Asynchronous reset while the writer is busy
      rate_div = 16'd3;
      push_sample(12'h0AB);
      push_sample(12'h0CD);
      base = n_latch;
      run = 1'b1;
      wait_latches(base + 1, 50, "rst_test_latch");
      repeat (5) @(negedge clk);
      check("pre_rst_level", fifo_level, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_enable", enable, 0);
      check("async_rst_level", fifo_level, 0);
      check("async_rst_ch_value", ch_value, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = n_latch;
      repeat (30) @(negedge clk);
      check("post_rst_no_enable", n_latch, base);
      check("post_rst_enable_low", enable, 0);
      run = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
